// File: rtl/queue_op_initiator.sv
// rtl/queue_op_initiator.sv - one-at-a-time requester for the six-operation queue controller
// Latches a command, drives the matching req until its cpl (or a timeout), then returns a response.
module queue_op_initiator #(
    parameter int p_depth     = 32,
    parameter int p_ptrwidth  = $clog2(p_depth),
    parameter int p_chanwidth = 32,
    parameter int p_timeout   = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   cmd_val_i,
    output logic                   cmd_rdy_o,
    input  logic [2:0]             cmd_op_i,
    input  logic [p_ptrwidth-1:0]  cmd_tag_i,
    input  logic [p_chanwidth-1:0] cmd_data_i,

    output logic                   rsp_val_o,
    input  logic                   rsp_rdy_i,
    output logic [2:0]             rsp_op_o,
    output logic [p_ptrwidth-1:0]  rsp_tag_o,
    output logic [p_chanwidth-1:0] rsp_data_o,
    output logic [1:0]             rsp_status_o,
    output logic                   err_stray_o,

    output logic                   enq_back_req_o,
    output logic                   enq_front_req_o,
    output logic                   deq_front_req_o,
    output logic                   deq_back_req_o,
    output logic                   upd_req_o,
    output logic                   del_req_o,

    input  logic                   enq_back_cpl_i,
    input  logic                   enq_front_cpl_i,
    input  logic                   deq_front_cpl_i,
    input  logic                   deq_back_cpl_i,
    input  logic                   upd_cpl_i,
    input  logic                   del_cpl_i,

    output logic [p_chanwidth-1:0] enq_back_data_o,
    output logic [p_chanwidth-1:0] enq_front_data_o,
    output logic [p_chanwidth-1:0] upd_data_in_o,
    output logic [p_ptrwidth-1:0]  upd_tag_in_o,
    output logic [p_ptrwidth-1:0]  del_tag_in_o,

    input  logic [p_ptrwidth-1:0]  enq_back_tag_out_i,
    input  logic [p_ptrwidth-1:0]  enq_front_tag_out_i,
    input  logic [p_chanwidth-1:0] deq_front_data_i,
    input  logic [p_chanwidth-1:0] deq_back_data_i
);

    localparam int CW = $clog2(p_timeout + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(p_timeout - 1);

    localparam logic [2:0] OP_ENQ_BACK  = 3'd0;
    localparam logic [2:0] OP_ENQ_FRONT = 3'd1;
    localparam logic [2:0] OP_DEQ_FRONT = 3'd2;
    localparam logic [2:0] OP_DEQ_BACK  = 3'd3;
    localparam logic [2:0] OP_UPD       = 3'd4;
    localparam logic [2:0] OP_DEL       = 3'd5;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_BADOP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t                 state_q;
    logic [2:0]             op_q;
    logic [p_ptrwidth-1:0]  tag_q;
    logic [p_chanwidth-1:0] data_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [2:0]             rsp_op_q;
    logic [p_ptrwidth-1:0]  rsp_tag_q;
    logic [p_chanwidth-1:0] rsp_data_q;
    logic [1:0]             rsp_status_q;
    logic                   err_stray_q;

    logic [5:0]             cpl_vec;
    logic [5:0]             op_onehot;
    logic [5:0]             req_vec;
    logic                   cpl_match;
    logic                   stray;
    logic [p_ptrwidth-1:0]  cpl_tag;
    logic [p_chanwidth-1:0] cpl_data;
    logic [p_ptrwidth-1:0]  tmo_tag;

    assign cpl_vec = {del_cpl_i, upd_cpl_i, deq_back_cpl_i,
                      deq_front_cpl_i, enq_front_cpl_i, enq_back_cpl_i};

    // Opcodes 6/7 shift out of range and yield an all-zero mask.
    assign op_onehot = 6'b000001 << op_q;
    assign cpl_match = |(cpl_vec & op_onehot);

    // Req drops combinationally with its own cpl so the controller never sees it twice.
    assign req_vec = (state_q == S_ISSUE) ? (op_onehot & ~cpl_vec) : 6'b0;

    assign stray = (|cpl_vec) && ((state_q != S_ISSUE) || (|(cpl_vec & ~op_onehot)));

    assign cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        cpl_tag  = '0;
        cpl_data = '0;
        case (op_q)
            OP_ENQ_BACK:  cpl_tag  = enq_back_tag_out_i;
            OP_ENQ_FRONT: cpl_tag  = enq_front_tag_out_i;
            OP_DEQ_FRONT: cpl_data = deq_front_data_i;
            OP_DEQ_BACK:  cpl_data = deq_back_data_i;
            OP_UPD:       cpl_tag  = tag_q;
            OP_DEL:       cpl_tag  = tag_q;
            default: ;
        endcase
    end

    assign tmo_tag = ((op_q == OP_UPD) || (op_q == OP_DEL)) ? tag_q : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            rsp_op_q     <= '0;
            rsp_tag_q    <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            err_stray_q  <= 1'b0;
        end else begin
            if (stray) begin
                err_stray_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_val_i) begin
                        op_q   <= cmd_op_i;
                        tag_q  <= cmd_tag_i;
                        data_q <= cmd_data_i;
                        cnt_q  <= '0;
                        if (cmd_op_i > OP_DEL) begin
                            rsp_op_q     <= cmd_op_i;
                            rsp_tag_q    <= '0;
                            rsp_data_q   <= '0;
                            rsp_status_q <= ST_BADOP;
                            state_q      <= S_RESP;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // A matching cpl in the last allowed cycle still counts as success.
                    if (cpl_match) begin
                        rsp_op_q     <= op_q;
                        rsp_tag_q    <= cpl_tag;
                        rsp_data_q   <= cpl_data;
                        rsp_status_q <= ST_OK;
                        state_q      <= S_RESP;
                    end else if (cnt_q == TMO_LAST) begin
                        rsp_op_q     <= op_q;
                        rsp_tag_q    <= tmo_tag;
                        rsp_data_q   <= '0;
                        rsp_status_q <= ST_TIMEOUT;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    if (rsp_rdy_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_rdy_o    = (state_q == S_IDLE);
    assign rsp_val_o    = (state_q == S_RESP);
    assign rsp_op_o     = rsp_op_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign err_stray_o  = err_stray_q;

    assign enq_back_req_o  = req_vec[0];
    assign enq_front_req_o = req_vec[1];
    assign deq_front_req_o = req_vec[2];
    assign deq_back_req_o  = req_vec[3];
    assign upd_req_o       = req_vec[4];
    assign del_req_o       = req_vec[5];

    assign enq_back_data_o  = data_q;
    assign enq_front_data_o = data_q;
    assign upd_data_in_o    = data_q;
    assign upd_tag_in_o     = tag_q;
    assign del_tag_in_o     = tag_q;

endmodule

// File: tb/tb_queue_op_initiator.sv
// tb/tb_queue_op_initiator.sv - randomized self-checking bench for queue_op_initiator
// A cycle-level controller model answers reqs; expected responses come from the operation rules.
module tb_queue_op_initiator;

    localparam int PW  = 5;
    localparam int DW  = 32;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_val;
    logic          cmd_rdy;
    logic [2:0]    cmd_op;
    logic [PW-1:0] cmd_tag;
    logic [DW-1:0] cmd_data;
    logic          rsp_val;
    logic          rsp_rdy;
    logic [2:0]    rsp_op;
    logic [PW-1:0] rsp_tag;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic          err_stray;
    logic [5:0]    req_v;
    logic [5:0]    cpl;
    logic [DW-1:0] enq_back_data, enq_front_data, upd_data_in;
    logic [PW-1:0] upd_tag_in, del_tag_in;
    logic [PW-1:0] enq_back_tag_out, enq_front_tag_out;
    logic [DW-1:0] deq_front_data, deq_back_data;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_stray = 1'b0;

    always #5 clk = ~clk;

    queue_op_initiator dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cmd_val_i           (cmd_val),
        .cmd_rdy_o           (cmd_rdy),
        .cmd_op_i            (cmd_op),
        .cmd_tag_i           (cmd_tag),
        .cmd_data_i          (cmd_data),
        .rsp_val_o           (rsp_val),
        .rsp_rdy_i           (rsp_rdy),
        .rsp_op_o            (rsp_op),
        .rsp_tag_o           (rsp_tag),
        .rsp_data_o          (rsp_data),
        .rsp_status_o        (rsp_status),
        .err_stray_o         (err_stray),
        .enq_back_req_o      (req_v[0]),
        .enq_front_req_o     (req_v[1]),
        .deq_front_req_o     (req_v[2]),
        .deq_back_req_o      (req_v[3]),
        .upd_req_o           (req_v[4]),
        .del_req_o           (req_v[5]),
        .enq_back_cpl_i      (cpl[0]),
        .enq_front_cpl_i     (cpl[1]),
        .deq_front_cpl_i     (cpl[2]),
        .deq_back_cpl_i      (cpl[3]),
        .upd_cpl_i           (cpl[4]),
        .del_cpl_i           (cpl[5]),
        .enq_back_data_o     (enq_back_data),
        .enq_front_data_o    (enq_front_data),
        .upd_data_in_o       (upd_data_in),
        .upd_tag_in_o        (upd_tag_in),
        .del_tag_in_o        (del_tag_in),
        .enq_back_tag_out_i  (enq_back_tag_out),
        .enq_front_tag_out_i (enq_front_tag_out),
        .deq_front_data_i    (deq_front_data),
        .deq_back_data_i     (deq_back_data)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_payload(input logic [DW-1:0] p);
        enq_back_tag_out  = p[PW-1:0];
        enq_front_tag_out = p[PW-1:0];
        deq_front_data    = p;
        deq_back_data     = p;
    endtask

    // lat: index of the issue cycle carrying cpl (cycle 0 = first req cycle); >= TMO never completes.
    // wrong_at: issue cycle that also carries a non-matching cpl, or -1.
    task automatic run_cmd(input logic [2:0] op, input logic [PW-1:0] tag, input logic [DW-1:0] data,
                           input int lat, input logic [DW-1:0] payload, input int hold,
                           input int wrong_at, input bit late_cpl);
        int            k;
        int            req_cycles;
        int            other_cycles;
        bit            hold_ok;
        bit            stable_ok;
        logic [1:0]    e_status;
        logic [PW-1:0] e_tag;
        logic [DW-1:0] e_data;
        int            e_req;
        logic [DW+PW+4:0] snap;
        int            wb;

        e_status = (op > 3'd5) ? 2'd2 : ((lat < TMO) ? 2'd0 : 2'd1);
        e_tag    = (op <= 3'd1) ? payload[PW-1:0] : ((op == 3'd4 || op == 3'd5) ? tag : '0);
        e_data   = (op == 3'd2 || op == 3'd3) ? payload : '0;
        e_req    = (op > 3'd5) ? 0 : ((lat < TMO) ? lat : TMO);

        @(negedge clk);
        chk("cmd_rdy_idle", cmd_rdy, 1'b1);
        cmd_val = 1'b1; cmd_op = op; cmd_tag = tag; cmd_data = data;
        @(negedge clk);
        cmd_val = 1'b0; cmd_op = $urandom; cmd_tag = $urandom; cmd_data = $urandom;

        req_cycles = 0; other_cycles = 0; hold_ok = 1'b1; k = 0;
        if (op > 3'd5) begin
            chk("badop_req_none", req_v, 6'b0);
        end
        while (!rsp_val && k < TMO + 8) begin
            drive_payload(~payload);
            if (k == wrong_at) begin
                wb = (int'(op) + 1 + int'($urandom % 5)) % 6;
                cpl[wb] = 1'b1;
                exp_stray = 1'b1;
            end
            if (k == lat) begin
                cpl[op] = 1'b1;
                drive_payload(payload);
            end
            #1;
            if (req_v[op]) req_cycles++;
            if ((req_v & ~(6'b1 << op)) != 6'b0) other_cycles++;
            if (k == lat) chk("req_low_in_cpl", req_v[op], 1'b0);
            if (cmd_rdy !== 1'b0) hold_ok = 1'b0;
            case (op)
                3'd0: if (enq_back_data !== data) hold_ok = 1'b0;
                3'd1: if (enq_front_data !== data) hold_ok = 1'b0;
                3'd4: if (upd_data_in !== data || upd_tag_in !== tag) hold_ok = 1'b0;
                3'd5: if (del_tag_in !== tag) hold_ok = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            cpl = '0;
            k++;
        end
        chk("rsp_val_seen", rsp_val, 1'b1);
        if (op <= 3'd5) begin
            chk("req_cycles", req_cycles, e_req);
            chk("issue_hold", {other_cycles != 0, hold_ok}, 2'b01);
        end
        chk("rsp_op", rsp_op, op);
        chk("rsp_status", rsp_status, e_status);
        if (e_status != 2'd1) begin
            chk("rsp_tag", rsp_tag, e_tag);
            chk("rsp_data", rsp_data, e_data);
        end

        snap = {rsp_op, rsp_tag, rsp_data, rsp_status};
        stable_ok = 1'b1;
        if (late_cpl) begin
            @(negedge clk);
            cpl[op % 6] = 1'b1;
            exp_stray = 1'b1;
            @(negedge clk);
            cpl = '0;
            chk("late_cpl_stray", err_stray, 1'b1);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_val !== 1'b1 || cmd_rdy !== 1'b0) stable_ok = 1'b0;
            if ({rsp_op, rsp_tag, rsp_data, rsp_status} !== snap) stable_ok = 1'b0;
        end
        chk("rsp_stable", stable_ok, 1'b1);
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        chk("rsp_drop", {rsp_val, cmd_rdy}, 2'b01);
        chk("err_stray", err_stray, exp_stray);
    endtask

    initial begin
        rst = 1'b1; cmd_val = 1'b0; cmd_op = '0; cmd_tag = '0; cmd_data = '0;
        rsp_rdy = 1'b0; cpl = '0; drive_payload('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req", req_v, 6'b0);
        chk("reset_rsp_val", rsp_val, 1'b0);
        chk("reset_stray", err_stray, 1'b0);
        chk("reset_cmd_rdy", cmd_rdy, 1'b1);
        chk("reset_rsp_fields", {rsp_op, rsp_tag, rsp_data, rsp_status}, '0);

        run_cmd(3'd0, 5'd0, 32'hA5A5_0001, 1, 32'd5, 0, -1, 1'b0);
        run_cmd(3'd2, 5'd0, 32'h0, 1, 32'hDEAD_BEEF, 3, -1, 1'b0);
        run_cmd(3'd4, 5'd7, 32'h1234, 10, 32'h0, 1, -1, 1'b0);
        run_cmd(3'd3, 5'd3, 32'h0, TMO - 1, 32'h0BAD_F00D, 0, -1, 1'b0);
        run_cmd(3'd6, 5'd2, 32'h55, 0, 32'h0, 1, -1, 1'b0);
        run_cmd(3'd1, 5'd0, 32'h77, 1000, 32'h0, 2, -1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            int lat, sel, wat;
            op  = 3'($urandom % 8);
            sel = int'($urandom % 20);
            lat = (sel < 14) ? int'($urandom_range(0, 12)) :
                  (sel < 17) ? int'($urandom_range(TMO - 2, TMO)) : 1000;
            wat = ($urandom % 5 == 0) ? int'($urandom_range(0, (lat < TMO - 1) ? lat : TMO - 1)) : -1;
            run_cmd(op, 5'($urandom), $urandom, lat, $urandom, int'($urandom_range(0, 3)), wat,
                    (lat >= TMO && ($urandom % 2 == 1)));
        end

        @(negedge clk);
        cmd_val = 1'b1; cmd_op = 3'd4; cmd_tag = 5'd9; cmd_data = 32'h4444;
        @(negedge clk);
        cmd_val = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_req_before", upd_req_present(), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_drop", req_v, 6'b0);
        chk("midrst_no_rsp", rsp_val, 1'b0);
        rst = 1'b0;
        exp_stray = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_rdy", cmd_rdy, 1'b1);
        chk("midrst_idle_rsp", rsp_val, 1'b0);
        chk("midrst_stray_clr", err_stray, exp_stray);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic logic upd_req_present();
        return req_v[4];
    endfunction

endmodule
